store_and_release_lane: RTL
===========================

Name: store_and_release_lane

Overview:
- Per-lane storage unit for the multi-lane release controller; one instance per lane, NUM_STORAGES instances total.
- Buffers in-order result tuples tagged with a 32-bit sequence number and reports to the controller when the head tuple matches the controller's `next` index.
- On the controller's release pulse, moves the head into an output register and presents it downstream with valid/ready.
- Reports its own readiness and end-of-stream status back to the controller.

Parameters:
- DATA_W, 64, tuple payload width in bits.
- DEPTH, 16, buffer entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream tuple valid.
- s_ready  output  1  buffer can accept a tuple.
- s_data  input  DATA_W  upstream tuple payload.
- s_seq  input  32  sequence number of the tuple.
- s_last  input  1  tuple is the final one for this lane.
- next  input  32  controller's current release index.
- is_stored  output  1  head tuple present with sequence == next.
- release_data  input  1  controller release pulse for this lane.
- out_ready  output  1  output register free or draining this cycle.
- local_last_processed  output  1  last tuple accepted and buffer empty.
- m_valid  output  1  output tuple valid.
- m_ready  input  1  downstream accepts the output tuple.
- m_data  output  DATA_W  output tuple payload.
- seq_error  output  1  sticky protocol/sequence error.
- occupancy  output  CNT_W  number of buffered tuples.

Behaviour:
- Reset is asynchronous and active-high. While reset is high and after release, all of the following are 0: occupancy, pointers, m_valid, m_data, is_stored, local_last_processed, seq_error, last_seen. Reset mid-operation discards all buffered and output-register contents.
- Push: s_ready = (occupancy < DEPTH), derived from registered state only; there is no full-bypass. A push happens when s_valid && s_ready; {s_data, s_seq} is written at the write pointer.
- is_stored: combinational from registered state, (occupancy != 0) && (head_seq == next). A tuple pushed in cycle t can raise is_stored no earlier than cycle t+1.
- out_ready: combinational, ~m_valid || m_ready.
- Pop: pop = release_data && is_stored && out_ready. On the next edge, head {data} loads into m_data, m_valid=1, and the read pointer advances.
- Output register:
  - If m_valid && m_ready and no pop, m_valid clears and m_data holds its value.
  - If a pop coincides with m_ready, the new tuple loads and m_valid stays 1.
- Simultaneous push and pop: both occur and occupancy is unchanged. At DEPTH full, the push is refused (s_ready=0) even if a pop occurs in the same cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; occupancy is tracked separately.
- last_seen sets on an accepted push with s_last=1 and stays sticky until reset. Later pushes are still accepted.
- local_last_processed = last_seen && (occupancy == 0), registered and updated every cycle. It may deassert if a tuple is pushed after last.
- Sequence arithmetic is 32-bit unsigned equality only; there is no window or wrap compare.
- release_data while ~is_stored or ~out_ready: no pop, and seq_error sets (if enabled).

Optional Feature:
- SAR_SEQ_CHECK_EN defined:
  - s_seq is stored per entry; is_stored requires head_seq == next.
  - seq_error sets sticky when:
    - occupancy != 0 and head_seq < next (stale tuple), or
    - release_data is asserted without a pop.
- SAR_SEQ_CHECK_EN undefined:
  - s_seq is ignored and not stored (storage is DATA_W only).
  - is_stored = (occupancy != 0).
  - seq_error is tied to 0.

Test Plan:
- Reset, then push seqs 0,1,2 with data 0xA0,0xA1,0xA2, next=0, m_ready=1. Pulse release_data each cycle is_stored=1, incrementing next. -> m_data sequence 0xA0,0xA1,0xA2, each appearing one cycle after its release; occupancy returns to 0.
- Fill DEPTH=16 tuples with no release. -> s_ready=0 at occupancy 16; 17th s_valid not accepted. One release -> s_ready=1 next cycle.
- m_ready=0 with m_valid=1 -> out_ready=0; a release_data pulse leaves occupancy unchanged, m_data holds, and seq_error=1 (with SAR_SEQ_CHECK_EN).
- Push seq 5 while next=4 -> is_stored=0. next=5 -> is_stored=1. Push seq 3 at head with next=4 (check enabled) -> seq_error=1, sticky.
- Push seq 0 with s_last=1, then release. -> local_last_processed=0 while occupancy=1, =1 one cycle after occupancy reaches 0.
- Assert reset for one cycle with occupancy=7, m_valid=1 -> all outputs 0 immediately (asynchronous); s_ready=1 after reset deasserts.

Source files
------------

// File: rtl/store_and_release_lane.sv
// rtl/store_and_release_lane.sv - per-lane in-order tuple buffer with a released output register
// Optional: SAR_SEQ_CHECK_EN stores s_seq per entry, gates is_stored on head_seq == next and enables seq_error.
module store_and_release_lane #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [31:0]       s_seq,
  input  logic              s_last,
  input  logic [31:0]       next,
  output logic              is_stored,
  input  logic              release_data,
  output logic              out_ready,
  output logic              local_last_processed,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              seq_error,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              last_seen_q, last_seen_d;
  logic              llp_q;
  logic              seq_err_q, seq_err_d;
  logic              push, pop, head_match, seq_fault;

`ifdef SAR_SEQ_CHECK_EN
  logic [31:0] seq_mem [DEPTH];
  logic [31:0] head_seq;

  assign head_seq   = seq_mem[rd_ptr_q];
  assign head_match = (head_seq == next);
  // A stale head can never be released, and a release that does not pop is a controller fault.
  assign seq_fault  = ((occ_q != '0) && (head_seq < next)) || (release_data && !pop);

  always_ff @(posedge clk) begin
    if (push) seq_mem[wr_ptr_q] <= s_seq;
  end
`else
  logic unused_seq;

  assign unused_seq = ^{s_seq, next};
  assign head_match = 1'b1;
  assign seq_fault  = 1'b0;
`endif

  assign s_ready   = (occ_q < CNT_W'(DEPTH));
  assign is_stored = (occ_q != '0) && head_match;
  assign out_ready = !m_valid_q || m_ready;
  assign push      = s_valid && s_ready;
  assign pop       = release_data && is_stored && out_ready;

  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr_q] <= s_data;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    last_seen_d = last_seen_q;
    seq_err_d   = seq_err_q | seq_fault;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (s_last) last_seen_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      m_valid_d = 1'b1;
      m_data_d  = data_mem[rd_ptr_q];
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    if (push && !pop) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      last_seen_q <= 1'b0;
      llp_q       <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      last_seen_q <= last_seen_d;
      // Lags the drain by one cycle: reflects the state seen at this edge, not the one being written.
      llp_q       <= last_seen_q && (occ_q == '0);
      seq_err_q   <= seq_err_d;
    end
  end

  assign m_valid              = m_valid_q;
  assign m_data               = m_data_q;
  assign occupancy            = occ_q;
  assign local_last_processed = llp_q;
  assign seq_error            = seq_err_q;

endmodule
